rv_fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the core front end.
- Issues word-aligned read requests to instruction memory and tracks outstanding requests with a credit counter.
- Holds returning words in a small response skid FIFO and pushes them into rv_fetch_buf while it reports not-full.
- On redirect (branch/trap) it reloads the fetch buffer PC and discards stale in-flight responses without stalling new requests.

---
 rtl/rv_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_rv_fetch_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: instruction fetch sequencer. Issues word reads under a credit limit,
// parks returning words in a skid FIFO and feeds them to rv_fetch_buf.
module rv_fetch_ctrl #(
   parameter int                          IADDR_SPACE_BITS = 16,
   parameter int                          MAX_OUTSTANDING  = 2,
   parameter logic [IADDR_SPACE_BITS-1:0] RESET_PC         = '0
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_flush,
   input  logic [IADDR_SPACE_BITS-2:0]   i_flush_pc,
   input  logic                          i_halt,
   output logic                          o_halted,
   output logic                          o_mem_req,
   output logic [IADDR_SPACE_BITS-3:0]   o_mem_addr,
   input  logic                          i_mem_ack,
   input  logic                          i_mem_rvalid,
   input  logic [31:0]                   i_mem_rdata,
   input  logic                          i_buf_not_full,
   output logic                          o_buf_push,
   output logic [31:0]                   o_buf_data,
   output logic                          o_buf_flush,
   output logic [IADDR_SPACE_BITS-2:0]   o_buf_pc
);

   localparam int AW = IADDR_SPACE_BITS - 2;
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(MAX_OUTSTANDING);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]                  state_q, state_d;
   logic [AW-1:0]               fetchAddr_q, fetchAddr_d;
   logic [CW-1:0]               inflight_q, inflight_d;
   logic [CW-1:0]               discard_q, discard_d;
   logic [CW-1:0]               skidCnt_q, skidCnt_d;
   logic [PW-1:0]               rdPtr_q, rdPtr_d;
   logic [PW-1:0]               wrPtr_q, wrPtr_d;
   logic                        bufFlush_q;
   logic [IADDR_SPACE_BITS-2:0] bufPc_q, bufPc_d;
   logic [31:0]                 skidMem [MAX_OUTSTANDING];

   logic [CW:0] creditsUsed;
   logic        memAccept;
   logic        skidWrite;

   // Stale responses still count against credits, so a redirect never overruns the skid FIFO.
   assign creditsUsed = {1'b0, inflight_q} + {1'b0, skidCnt_q};
   assign o_mem_req   = (state_q == S_RUN) & ~i_halt & (creditsUsed < CREDITS);
   assign o_mem_addr  = fetchAddr_q;
   assign memAccept   = o_mem_req & i_mem_ack;
   assign skidWrite   = i_mem_rvalid & ~i_flush & (discard_q == '0);
   assign o_buf_push  = (skidCnt_q != '0) & i_buf_not_full & ~bufFlush_q & ~i_flush;
   assign o_buf_data  = skidMem[rdPtr_q];
   assign o_buf_flush = bufFlush_q;
   assign o_buf_pc    = bufPc_q;
   assign o_halted    = (state_q == S_HALT) & (inflight_q == '0);

   always_comb begin
      inflight_d = inflight_q;
      if (memAccept && !i_mem_rvalid) begin
         inflight_d = inflight_q + CW'(1);
      end else if (!memAccept && i_mem_rvalid) begin
         inflight_d = inflight_q - CW'(1);
      end

      // Everything still in flight after a redirect belongs to the old stream.
      discard_d = discard_q;
      if (i_flush) begin
         discard_d = inflight_d;
      end else if (i_mem_rvalid && discard_q != '0) begin
         discard_d = discard_q - CW'(1);
      end

      fetchAddr_d = fetchAddr_q;
      bufPc_d     = bufPc_q;
      if (i_flush) begin
         fetchAddr_d = i_flush_pc[IADDR_SPACE_BITS-2:1];
         bufPc_d     = i_flush_pc;
      end else if (memAccept) begin
         fetchAddr_d = fetchAddr_q + AW'(1);
      end
   end

   always_comb begin
      skidCnt_d = skidCnt_q;
      rdPtr_d   = rdPtr_q;
      wrPtr_d   = wrPtr_q;
      if (i_flush) begin
         skidCnt_d = '0;
         rdPtr_d   = '0;
         wrPtr_d   = '0;
      end else begin
         if (skidWrite) begin
            wrPtr_d = wrPtr_q + PW'(1);
         end
         if (o_buf_push) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         case ({skidWrite, o_buf_push})
            2'b10:   skidCnt_d = skidCnt_q + CW'(1);
            2'b01:   skidCnt_d = skidCnt_q - CW'(1);
            default: skidCnt_d = skidCnt_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   if (i_halt && inflight_d == '0) state_d = S_HALT;
         S_HALT:  if (!i_halt) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_BOOT;
         fetchAddr_q <= RESET_PC[IADDR_SPACE_BITS-1:2];
         inflight_q  <= '0;
         discard_q   <= '0;
         skidCnt_q   <= '0;
         rdPtr_q     <= '0;
         wrPtr_q     <= '0;
         bufFlush_q  <= 1'b1;
         bufPc_q     <= RESET_PC[IADDR_SPACE_BITS-1:1];
      end else begin
         state_q     <= state_d;
         fetchAddr_q <= fetchAddr_d;
         inflight_q  <= inflight_d;
         discard_q   <= discard_d;
         skidCnt_q   <= skidCnt_d;
         rdPtr_q     <= rdPtr_d;
         wrPtr_q     <= wrPtr_d;
         bufFlush_q  <= i_flush;
         bufPc_q     <= bufPc_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (skidWrite) begin
         skidMem[wrPtr_q] <= i_mem_rdata;
      end
   end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Scoreboard testbench for rv_fetch_ctrl: an in-order memory model tags each word with
// its address; expected pushes are queued on response and popped on o_buf_push.
module tb_rv_fetch_ctrl;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        i_reset, i_flush, i_halt, i_mem_ack, i_mem_rvalid, i_buf_not_full;
   logic [14:0] i_flush_pc;
   logic [31:0] i_mem_rdata;
   logic        o_halted, o_mem_req, o_buf_push, o_buf_flush;
   logic [13:0] o_mem_addr;
   logic [31:0] o_buf_data;
   logic [14:0] o_buf_pc;

   rv_fetch_ctrl #(
      .IADDR_SPACE_BITS(16),
      .MAX_OUTSTANDING(MAXO),
      .RESET_PC(16'h0100)
   ) dut (
      .i_clk(clk),
      .i_reset(i_reset),
      .i_flush(i_flush),
      .i_flush_pc(i_flush_pc),
      .i_halt(i_halt),
      .o_halted(o_halted),
      .o_mem_req(o_mem_req),
      .o_mem_addr(o_mem_addr),
      .i_mem_ack(i_mem_ack),
      .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata),
      .i_buf_not_full(i_buf_not_full),
      .o_buf_push(o_buf_push),
      .o_buf_data(o_buf_data),
      .o_buf_flush(o_buf_flush),
      .o_buf_pc(o_buf_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] addr;
      bit          stale;
      int          due;
   } memEntry_t;

   memEntry_t   memQ[$];
   logic [31:0] expQ[$];
   logic [13:0] accLog[$];
   logic [31:0] pushLog[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;
   logic ackEn, rvHold, notFull, halt;
   logic [13:0] expAddr;
   logic [14:0] expPc;
   logic expFlush;
   logic obsReq, obsPush, obsHalted, obsFlush, acc, rv;
   logic [13:0] obsAddr;
   logic [14:0] obsPc;

   function automatic logic [31:0] tagOf(input logic [13:0] a);
      return {16'hC0DE, 2'b00, a};
   endfunction

   // One clock: drive at the falling edge, sample 1 time unit later, update the model.
   task automatic cycle(input logic flush, input logic [14:0] fpc);
      memEntry_t e;
      logic [31:0] want;
      @(negedge clk);
      rv = (memQ.size() > 0) && !rvHold && (memQ[0].due <= cyc);
      i_flush        = flush;
      i_flush_pc     = fpc;
      i_halt         = halt;
      i_buf_not_full = notFull;
      i_mem_ack      = ackEn;
      i_mem_rvalid   = rv;
      i_mem_rdata    = rv ? tagOf(memQ[0].addr) : 32'h0;
      #1;
      obsReq    = o_mem_req;
      obsAddr   = o_mem_addr;
      obsPush   = o_buf_push;
      obsHalted = o_halted;
      obsFlush  = o_buf_flush;
      obsPc     = o_buf_pc;
      acc       = o_mem_req & ackEn;
      checks++;
      if (o_buf_flush !== expFlush) begin
         failures++;
         $display("[TB] FAIL buf_flush cyc=%0d: got %0b want %0b", cyc, o_buf_flush, expFlush);
      end
      checks++;
      if (o_buf_pc !== expPc) begin
         failures++;
         $display("[TB] FAIL buf_pc cyc=%0d: got %0h want %0h", cyc, o_buf_pc, expPc);
      end
      if (o_mem_req) begin
         checks++;
         if (memQ.size() + expQ.size() >= MAXO) begin
            failures++;
            $display("[TB] FAIL credit cyc=%0d: got used=%0d want below %0d", cyc,
                     memQ.size() + expQ.size(), MAXO);
         end
      end
      if (o_buf_push) begin
         checks++;
         pushLog.push_back(o_buf_data);
         if (flush || expFlush) begin
            failures++;
            $display("[TB] FAIL push_blocked cyc=%0d: got push=1 want push=0", cyc);
         end else if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL push_unexpected cyc=%0d: got %0h want no push", cyc, o_buf_data);
         end else begin
            want = expQ.pop_front();
            if (o_buf_data !== want) begin
               failures++;
               $display("[TB] FAIL push_data cyc=%0d: got %0h want %0h", cyc, o_buf_data, want);
            end
         end
      end
      if (rv) begin
         e = memQ.pop_front();
         if (!e.stale && !flush) expQ.push_back(tagOf(e.addr));
      end
      if (acc) begin
         checks++;
         accLog.push_back(o_mem_addr);
         if (o_mem_addr !== expAddr) begin
            failures++;
            $display("[TB] FAIL mem_addr cyc=%0d: got %0h want %0h", cyc, o_mem_addr, expAddr);
         end
         e.addr  = expAddr;
         e.stale = 1'b0;
         e.due   = cyc + lat;
         memQ.push_back(e);
         expAddr = expAddr + 14'd1;
      end
      if (flush) begin
         for (int i = 0; i < memQ.size(); i++) memQ[i].stale = 1'b1;
         expQ.delete();
         expAddr = fpc[14:1];
         expPc   = fpc;
      end
      expFlush = flush;
      cyc++;
   endtask

   // Reset, release at a falling edge and check the single BOOT cycle.
   task automatic applyReset();
      @(negedge clk);
      i_reset = 1'b1;
      i_flush = 1'b0;
      i_halt = 1'b0;
      i_mem_ack = 1'b0;
      i_mem_rvalid = 1'b0;
      halt = 1'b0;
      ackEn = 1'b0;
      rvHold = 1'b0;
      notFull = 1'b1;
      lat = 1;
      memQ.delete();
      expQ.delete();
      accLog.delete();
      pushLog.delete();
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_mem_req !== 1'b0) begin
         failures++;
         $display("[TB] FAIL boot_req: got %0b want 0", o_mem_req);
      end
      checks++;
      if (o_buf_flush !== 1'b1) begin
         failures++;
         $display("[TB] FAIL boot_flush: got %0b want 1", o_buf_flush);
      end
      expAddr = 14'h0040;
      expPc = 15'h0080;
      expFlush = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %0b want 0", o_mem_req); end
      checks++;
      if (o_buf_push !== 1'b0) begin failures++; $display("[TB] FAIL rst_push: got %0b want 0", o_buf_push); end
      checks++;
      if (o_buf_flush !== 1'b1) begin failures++; $display("[TB] FAIL rst_flush: got %0b want 1", o_buf_flush); end
      checks++;
      if (o_buf_pc !== 15'h0080) begin failures++; $display("[TB] FAIL rst_pc: got %0h want 80", o_buf_pc); end
      checks++;
      if (o_mem_addr !== 14'h0040) begin failures++; $display("[TB] FAIL rst_addr: got %0h want 40", o_mem_addr); end
      checks++;
      if (o_halted !== 1'b0) begin failures++; $display("[TB] FAIL rst_halted: got %0b want 0", o_halted); end
   endtask

   task automatic test_boot();
      int firstRv;
      int firstPush;
      applyReset();
      ackEn = 1'b1;
      firstRv = -1;
      firstPush = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 15'h0);
         if (rv && firstRv < 0) firstRv = cyc - 1;
         if (obsPush && firstPush < 0) firstPush = cyc - 1;
      end
      checks++;
      if (accLog.size() < 3 || accLog[0] !== 14'h40 || accLog[1] !== 14'h41 || accLog[2] !== 14'h42) begin
         failures++;
         $display("[TB] FAIL boot_seq: got %0d requests want 40,41,42 first", accLog.size());
      end
      checks++;
      if (firstRv < 0 || firstPush !== firstRv + 1) begin
         failures++;
         $display("[TB] FAIL boot_latency: got push cyc %0d want %0d", firstPush, firstRv + 1);
      end
      checks++;
      if (pushLog.size() == 0 || pushLog[0] !== tagOf(14'h40)) begin
         failures++;
         $display("[TB] FAIL boot_first_push: got %0d pushes want first %0h", pushLog.size(), tagOf(14'h40));
      end
   endtask

   task automatic test_backpressure();
      int n;
      applyReset();
      ackEn = 1'b1;
      notFull = 1'b0;
      for (int i = 0; i < 8; i++) cycle(1'b0, 15'h0);
      checks++;
      if (accLog.size() != 2) begin
         failures++;
         $display("[TB] FAIL bp_requests: got %0d want 2", accLog.size());
      end
      checks++;
      if (obsReq !== 1'b0 || pushLog.size() != 0) begin
         failures++;
         $display("[TB] FAIL bp_stalled: got req=%0b pushes=%0d want req=0 pushes=0", obsReq, pushLog.size());
      end
      notFull = 1'b1;
      cycle(1'b0, 15'h0);
      checks++;
      if (obsPush !== 1'b1) begin failures++; $display("[TB] FAIL bp_push1: got %0b want 1", obsPush); end
      cycle(1'b0, 15'h0);
      checks++;
      if (obsPush !== 1'b1) begin failures++; $display("[TB] FAIL bp_push2: got %0b want 1", obsPush); end
      n = 0;
      while (accLog.size() < 3 && n < 4) begin
         cycle(1'b0, 15'h0);
         n++;
      end
      checks++;
      if (accLog.size() < 3 || accLog[2] !== 14'h42) begin
         failures++;
         $display("[TB] FAIL bp_resume: got %0d requests want third at 42", accLog.size());
      end
   endtask

   task automatic test_flush_inflight();
      applyReset();
      ackEn = 1'b1;
      lat = 3;
      cycle(1'b0, 15'h0);
      cycle(1'b0, 15'h0);
      checks++;
      if (accLog.size() != 2) begin
         failures++;
         $display("[TB] FAIL fl_inflight: got %0d want 2", accLog.size());
      end
      cycle(1'b1, 15'h0105);
      cycle(1'b0, 15'h0);
      checks++;
      if (obsAddr !== 14'h0082 || obsPc !== 15'h0105 || obsFlush !== 1'b1) begin
         failures++;
         $display("[TB] FAIL fl_redirect: got addr=%0h pc=%0h flush=%0b want 82 105 1", obsAddr, obsPc, obsFlush);
      end
      for (int i = 0; i < 12; i++) cycle(1'b0, 15'h0);
      checks++;
      if (pushLog.size() == 0 || pushLog[0] !== tagOf(14'h0082)) begin
         failures++;
         $display("[TB] FAIL fl_first_push: got %0d pushes want first %0h", pushLog.size(), tagOf(14'h0082));
      end
   endtask

   task automatic test_flush_coincident();
      int bad;
      applyReset();
      ackEn = 1'b1;
      cycle(1'b0, 15'h0);
      cycle(1'b1, 15'h0180);
      checks++;
      if (!(acc && rv)) begin
         failures++;
         $display("[TB] FAIL fc_setup: got ack=%0b rvalid=%0b want 1 1", acc, rv);
      end
      for (int i = 0; i < 8; i++) cycle(1'b0, 15'h0);
      bad = 0;
      for (int i = 0; i < pushLog.size(); i++)
         if (pushLog[i] === tagOf(14'h40) || pushLog[i] === tagOf(14'h41)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL fc_stale_pushed: got %0d stale words want 0", bad);
      end
      checks++;
      if (accLog.size() < 3 || accLog[1] !== 14'h41 || accLog[2] !== 14'h00C0) begin
         failures++;
         $display("[TB] FAIL fc_addr_seq: got %0d requests want 40,41,C0", accLog.size());
      end
      checks++;
      if (pushLog.size() == 0 || pushLog[0] !== tagOf(14'h00C0)) begin
         failures++;
         $display("[TB] FAIL fc_first_push: got %0d pushes want first %0h", pushLog.size(), tagOf(14'h00C0));
      end
   endtask

   task automatic test_halt();
      int lastRv;
      int haltCyc;
      int n;
      applyReset();
      ackEn = 1'b1;
      lat = 3;
      cycle(1'b0, 15'h0);
      cycle(1'b0, 15'h0);
      halt = 1'b1;
      lastRv = -1;
      haltCyc = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 15'h0);
         if (rv) lastRv = cyc - 1;
         if (obsHalted && haltCyc < 0) haltCyc = cyc - 1;
      end
      checks++;
      if (accLog.size() != 2) begin
         failures++;
         $display("[TB] FAIL halt_no_req: got %0d requests want 2", accLog.size());
      end
      checks++;
      if (lastRv < 0 || haltCyc !== lastRv + 1) begin
         failures++;
         $display("[TB] FAIL halt_timing: got halted cyc %0d want %0d", haltCyc, lastRv + 1);
      end
      halt = 1'b0;
      n = 0;
      while (accLog.size() < 3 && n < 5) begin
         cycle(1'b0, 15'h0);
         n++;
      end
      checks++;
      if (accLog.size() < 3 || accLog[2] !== 14'h42) begin
         failures++;
         $display("[TB] FAIL halt_resume: got %0d requests want third at 42", accLog.size());
      end
   endtask

   task automatic test_wrap_and_reset();
      int idx;
      int n;
      applyReset();
      ackEn = 1'b1;
      cycle(1'b1, 15'h7FFE);
      for (int i = 0; i < 6; i++) cycle(1'b0, 15'h0);
      idx = -1;
      for (int i = 0; i < accLog.size(); i++) if (accLog[i] === 14'h3FFF && idx < 0) idx = i;
      checks++;
      if (idx < 0 || idx + 1 >= accLog.size() || accLog[idx+1] !== 14'h0000) begin
         failures++;
         $display("[TB] FAIL wrap: got all-ones at index %0d of %0d want next addr 0", idx, accLog.size());
      end
      n = 0;
      while (!(obsReq && obsPush) && n < 10) begin
         cycle(1'b0, 15'h0);
         n++;
      end
      checks++;
      if (!(obsReq && obsPush)) begin
         failures++;
         $display("[TB] FAIL async_setup: got req=%0b push=%0b want 1 1", obsReq, obsPush);
      end
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_buf_push !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: got req=%0b push=%0b want 0 0", o_mem_req, o_buf_push);
      end
      applyReset();
   endtask

   initial begin
      i_reset = 1'b1;
      i_flush = 1'b0;
      i_flush_pc = '0;
      i_halt = 1'b0;
      i_mem_ack = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = '0;
      i_buf_not_full = 1'b1;
      test_reset();
      test_boot();
      test_backpressure();
      test_flush_inflight();
      test_flush_coincident();
      test_halt();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
